// File: rtl/inst_fetch_pkg.sv
// Shared constants for the sMIPS instruction-fetch stage.
// Bus widths, reset values and the sequential PC increment.
package inst_fetch_pkg;

   localparam int          INST_ADDR_W  = 32;
   localparam int          INST_W       = 32;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic        RST_ENABLE   = 1'b0;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_INCR      = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear beats hold beats load.
// A misaligned fetch is captured as a NOP tagged with id_adel.
module if_id_reg
   import inst_fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   hold,
   input  logic                   load,
   input  logic [INST_ADDR_W-1:0] pc,
   input  logic [INST_W-1:0]      inst,
   input  logic                   adel,
   output logic [INST_ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0]      id_inst,
   output logic                   id_valid,
   output logic                   id_adel
);

   always_ff @(posedge clk) begin
      if (rst_n == RST_ENABLE) begin
         id_pc    <= '0;
         id_inst  <= ZERO_WORD;
         id_valid <= 1'b0;
         id_adel  <= 1'b0;
      end else if (clear) begin
         id_inst  <= ZERO_WORD;
         id_valid <= 1'b0;
         id_adel  <= 1'b0;
      end else if (!hold && load) begin
         id_pc    <= pc;
         id_inst  <= adel ? ZERO_WORD : inst;
         id_valid <= 1'b1;
         id_adel  <= adel;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// sMIPS fetch stage: PC, pending redirect and IF/ID capture.
// Priority per edge: exception > stall > redirect > sequential.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter bit          DELAY_SLOT = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall,
   input  logic                   br_taken,
   input  logic [INST_ADDR_W-1:0] br_target,
   input  logic                   exc_req,
   input  logic [INST_ADDR_W-1:0] exc_vector,
   output logic [INST_ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0]      imem_inst,
   output logic [INST_ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0]      id_inst,
   output logic                   id_valid,
   output logic                   id_adel
);

   logic [INST_ADDR_W-1:0] pc;
   logic [INST_ADDR_W-1:0] pend_target;
   logic                   pend_valid;
   logic                   redir;
   logic [INST_ADDR_W-1:0] redir_target;
   logic                   squash;
   logic                   misaligned;

   assign imem_addr    = pc;
   assign misaligned   = pc[1:0] != 2'b00;
   assign redir        = br_taken | pend_valid;
   assign redir_target = br_taken ? br_target : pend_target;
   assign squash       = !stall && redir && !DELAY_SLOT;

   always_ff @(posedge clk) begin
      if (rst_n == RST_ENABLE) begin
         pc          <= RESET_PC;
         pend_valid  <= 1'b0;
         pend_target <= '0;
      end else if (exc_req) begin
         pc          <= exc_vector;
         pend_valid  <= 1'b0;
      end else if (stall) begin
         // Remember a redirect that arrives while frozen; the latest one wins.
         if (br_taken) begin
            pend_valid  <= 1'b1;
            pend_target <= br_target;
         end
      end else if (redir) begin
         pc          <= redir_target;
         pend_valid  <= 1'b0;
      end else begin
         pc          <= pc + PC_INCR;
      end
   end

   if_id_reg u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (exc_req | squash),
      .hold     (stall),
      .load     (1'b1),
      .pc       (pc),
      .inst     (imem_inst),
      .adel     (misaligned),
      .id_pc    (id_pc),
      .id_inst  (id_inst),
      .id_valid (id_valid),
      .id_adel  (id_adel)
   );

endmodule
